// File: rtl/bf_pair_feeder_if.sv
// bf_pair_feeder_if
//  Handshake bundle between the sample source, the pair feeder and the
//  stage-0 butterfly.
//  Input stream:  in_valid/in_ready/in_data/in_last (one sample per handshake).
//  Output stream: out_valid/out_ready/out_x0/out_x1/out_pair/out_first/out_last.
//  Status:        frame_err (one-cycle pulse on a framing error).
//  Handshake rule for both streams: a transfer happens on a rising clk edge
//  where valid and ready are both high. A source holds its payload stable and
//  keeps valid high until the transfer. Ready may change freely and never
//  depends combinationally on valid.
//  Modports: slave = the feeder, master = whoever drives the feeder and
//  consumes its pairs.
interface bf_pair_feeder_if #(
    parameter int DW = 16
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_x0;
    logic [DW-1:0] out_x1;
    logic [1:0]    out_pair;
    logic          out_first;
    logic          out_last;
    logic          frame_err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_x0, out_x1, out_pair,
               out_first, out_last, frame_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_x0, out_x1, out_pair,
               out_first, out_last, frame_err
    );
endinterface

// File: rtl/bf_pair_feeder.sv
// bf_pair_feeder
//  Frame loader for the first radix-2 stage of an 8-point FFT/IFFT.
//  Samples x[0]..x[7] arrive in natural order and are stored in one bank of
//  a two-bank ping-pong buffer. A completed bank is emitted as four operand
//  pairs in bit-reversed DIT order (x0,x4),(x2,x6),(x1,x5),(x3,x7) while the
//  other bank is loaded with the next frame. Data passes unchanged.
//  Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears the buffer and drops all frames
//   bus    bf_pair_feeder_if.slave (input stream, output pairs, frame_err)
module bf_pair_feeder #(
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bf_pair_feeder_if.slave       bus
);

    logic [DW-1:0] mem [2][8];
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;
    logic          wr_bank;
    logic [2:0]    wr_idx;
    logic          rd_bank;
    logic [1:0]    rd_pair;
    logic          frame_err_q;

    logic          accept;
    logic          take;
    logic          frame_done;
    logic          frame_bad;
    logic          read_done;
    logic [2:0]    rd_idx0;

    assign bus.in_ready  = !bank_full[wr_bank];
    assign bus.out_valid = bank_full[rd_bank];

    assign accept     = bus.in_valid && bus.in_ready;
    assign take       = bus.out_valid && bus.out_ready;
    assign frame_done = accept && (wr_idx == 3'd7) && bus.in_last;
    // A misplaced in_last or a missing one on the 8th sample both abort the frame.
    assign frame_bad  = accept && ((wr_idx == 3'd7) != bus.in_last);
    assign read_done  = take && (rd_pair == 2'd3);

    // Bit-reversing the 2-bit pair index gives the low half of the first
    // operand's index; the second operand is always 4 positions later.
    assign rd_idx0 = {1'b0, rd_pair[0], rd_pair[1]};

    assign bus.out_x0    = mem[rd_bank][rd_idx0];
    assign bus.out_x1    = mem[rd_bank][rd_idx0 | 3'd4];
    assign bus.out_pair  = rd_pair;
    assign bus.out_first = bus.out_valid && (rd_pair == 2'd0);
    assign bus.out_last  = bus.out_valid && (rd_pair == 2'd3);
    assign bus.frame_err = frame_err_q;

    // The writer only ever fills a non-full bank and the reader only drains a
    // full one, so a set and a clear in the same cycle touch different banks.
    always_comb begin
        bank_full_nxt = bank_full;
        if (read_done) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (frame_done) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    mem[b][i] <= '0;
                end
            end
            bank_full   <= 2'b00;
            wr_bank     <= 1'b0;
            wr_idx      <= 3'd0;
            rd_bank     <= 1'b0;
            rd_pair     <= 2'd0;
            frame_err_q <= 1'b0;
        end else begin
            bank_full   <= bank_full_nxt;
            frame_err_q <= frame_bad;

            if (accept) begin
                mem[wr_bank][wr_idx] <= bus.in_data;
                if (frame_done) begin
                    wr_bank <= ~wr_bank;
                    wr_idx  <= 3'd0;
                end else if (frame_bad) begin
                    wr_idx <= 3'd0;
                end else begin
                    wr_idx <= wr_idx + 3'd1;
                end
            end

            if (take) begin
                if (read_done) begin
                    rd_bank <= ~rd_bank;
                    rd_pair <= 2'd0;
                end else begin
                    rd_pair <= rd_pair + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bf_pair_feeder.sv
// tb_bf_pair_feeder
//  Bench for bf_pair_feeder. The reference model collects accepted samples
//  into a frame and, when a frame completes cleanly, pushes its four expected
//  pairs (pair index, first, second operand) onto exp_q. A monitor compares
//  every presented pair against the head of exp_q and pops on a take.
module tb_bf_pair_feeder;

    localparam int DW = 16;

    localparam int MODE_LOW    = 0;
    localparam int MODE_HIGH   = 1;
    localparam int MODE_TOGGLE = 2;
    localparam int MODE_RAND   = 3;
    localparam int MODE_MANUAL = 4;

    logic clk;
    logic reset;

    bf_pair_feeder_if #(.DW(DW)) bus ();

    bf_pair_feeder #(.DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [2+2*DW-1:0] exp_q[$];
    logic [DW-1:0]     cur[$];
    int                exp_err;
    int                check_cnt;
    int                pass_cnt;
    int                rdy_mode;
    logic              prev_stall;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        check_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference model: a frame is exactly 8 samples with in_last on the 8th.
    // Anything else is a framing error and the frame contributes no pairs.
    task automatic model_accept(input logic [DW-1:0] d, input logic last);
        int order[4];
        order = '{0, 2, 1, 3};
        cur.push_back(d);
        if (last || cur.size() == 8) begin
            if (last && cur.size() == 8) begin
                for (int p = 0; p < 4; p++) begin
                    exp_q.push_back({p[1:0], cur[order[p]], cur[order[p] + 4]});
                end
            end else begin
                exp_err++;
            end
            cur.delete();
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur.delete();
        exp_err = 0;
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [DW-1:0] d, input logic last);
        int budget;
        budget = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            check(1'b0, "in_ready_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(d, last);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] f[8]);
        for (int i = 0; i < 8; i++) send(f[i], i == 7);
    endtask

    task automatic send_seq(input int base);
        for (int i = 0; i < 8; i++) send(DW'(base + i), i == 7);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        check(exp_q.size() == 0, "drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- out_ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            MODE_LOW:    bus.out_ready = 1'b0;
            MODE_HIGH:   bus.out_ready = 1'b1;
            MODE_TOGGLE: bus.out_ready = ~bus.out_ready;
            MODE_RAND:   bus.out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [2+2*DW-1:0] e;
        logic [2+2*DW-1:0] a;
        if (!reset) begin
            if (bus.frame_err) begin
                check(exp_err > 0, "frame_err_unexpected", 64'd1, 64'd0);
                if (exp_err > 0) exp_err--;
            end
            if (prev_stall) begin
                check(bus.out_valid == 1'b1, "valid_dropped_while_stalled",
                      64'(bus.out_valid), 64'd1);
            end
            if (bus.out_valid) begin
                a = {bus.out_pair, bus.out_x0, bus.out_x1};
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_pair", 64'(a), 64'd0);
                end else begin
                    e = exp_q[0];
                    check(a == e, "pair_data", 64'(a), 64'(e));
                    check(bus.out_first == (e[2*DW+1:2*DW] == 2'd0), "out_first",
                          64'(bus.out_first), 64'(e[2*DW+1:2*DW] == 2'd0));
                    check(bus.out_last == (e[2*DW+1:2*DW] == 2'd3), "out_last",
                          64'(bus.out_last), 64'(e[2*DW+1:2*DW] == 2'd3));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] f[8];
        check_cnt     = 0;
        pass_cnt      = 0;
        exp_err       = 0;
        prev_stall    = 1'b0;
        rdy_mode      = MODE_LOW;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        check(bus.in_ready == 1'b1, "reset_in_ready", 64'(bus.in_ready), 64'd1);
        check(bus.out_valid == 1'b0, "reset_out_valid", 64'(bus.out_valid), 64'd0);
        check(bus.out_x0 == '0, "reset_out_x0", 64'(bus.out_x0), 64'd0);
        check(bus.out_x1 == '0, "reset_out_x1", 64'(bus.out_x1), 64'd0);
        check(bus.frame_err == 1'b0, "reset_frame_err", 64'(bus.frame_err), 64'd0);

        // Test 1: single frame 1..8, latency of out_valid
        rdy_mode = MODE_HIGH;
        for (int i = 0; i < 7; i++) send(DW'(i + 1), 1'b0);
        @(negedge clk);
        check(bus.out_valid == 1'b0, "valid_before_8th", 64'(bus.out_valid), 64'd0);
        send(DW'(8), 1'b1);
        @(negedge clk);
        check(bus.out_valid == 1'b1, "valid_after_8th", 64'(bus.out_valid), 64'd1);
        wait_drain();

        // Test 2: three back-to-back frames with the consumer stalled
        rdy_mode = MODE_LOW;
        repeat (2) @(posedge clk);
        send_seq(1);
        send_seq(9);
        @(negedge clk);
        check(bus.in_ready == 1'b0, "in_ready_both_full", 64'(bus.in_ready), 64'd0);
        rdy_mode = MODE_HIGH;
        send_seq(17);
        wait_drain();

        // Test 3: consumer toggling every cycle
        rdy_mode = MODE_TOGGLE;
        send_seq(1);
        wait_drain();

        // Test 4: in_last on the 5th sample, then a clean frame 10..17
        rdy_mode = MODE_HIGH;
        for (int i = 0; i < 5; i++) send(DW'(100 + i), i == 4);
        repeat (3) @(posedge clk);
        check(exp_err == 0, "err_pulse_seen_misplaced_last", 64'(exp_err), 64'd0);
        send_seq(10);
        wait_drain();

        // Missing in_last on the 8th sample, then a clean frame
        for (int i = 0; i < 8; i++) send(DW'(200 + i), 1'b0);
        repeat (3) @(posedge clk);
        check(exp_err == 0, "err_pulse_seen_missing_last", 64'(exp_err), 64'd0);
        send_seq(30);
        wait_drain();

        // Test 5: signed extremes pass through unchanged
        f = '{16'h8000, 16'h7fff, 16'hffff, 16'h0000,
              16'h8000, 16'h7fff, 16'hffff, 16'h0000};
        send_frame(f);
        f = '{16'h0000, 16'h8000, 16'h7fff, 16'hffff,
              16'hffff, 16'h0000, 16'h8000, 16'h7fff};
        send_frame(f);
        wait_drain();

        // Randomized frames with random consumer stalls and input gaps
        rdy_mode = MODE_RAND;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++) begin
                f[i] = DW'($urandom);
            end
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                send(f[i], i == 7);
            end
        end
        wait_drain();

        // Test 6: reset after two pairs taken and three samples of the next frame
        rdy_mode = MODE_LOW;
        repeat (2) @(posedge clk);
        send_seq(40);
        rdy_mode = MODE_MANUAL;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check(exp_q.size() == 2, "two_pairs_taken", 64'(exp_q.size()), 64'd2);
        for (int i = 0; i < 3; i++) send(DW'(60 + i), 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check(bus.out_valid == 1'b0, "post_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check(bus.in_ready == 1'b1, "post_reset_in_ready", 64'(bus.in_ready), 64'd1);
        check(bus.out_x0 == '0, "post_reset_out_x0", 64'(bus.out_x0), 64'd0);
        rdy_mode = MODE_HIGH;
        send_seq(70);
        wait_drain();

        repeat (4) @(posedge clk);
        check(exp_err == 0, "pending_frame_err", 64'(exp_err), 64'd0);
        check(cur.size() == 0, "partial_frame_left", 64'(cur.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
